quad_encoder_emulator: RTL and testbench

Generates two-channel quadrature encoder waveforms (pinA/pinB) at a programmable RPM and direction, emulating the motor encoder seen by the RPM tachometer. It sits on the same 100 MHz AXI clock domain and is used for closed-loop bring-up and regression of the tachometer path without a physical motor. A sequential divider converts the requested RPM into a quadrature step period.

---
 rtl/quad_encoder_emulator.sv | 174 +++++++++++++++++
 tb/tb_quad_encoder_emulator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_emulator.sv
// quad_encoder_emulator: two-channel quadrature encoder waveform generator.
// A 40-cycle restoring divider turns the requested RPM into a step period;
// pinA/pinB walk the Gray sequence at that rate in the chosen direction.
// Optional index output: define QENC_INDEX_EN to drive pinZ once per
// revolution; otherwise pinZ is tied low and no index logic exists.
module quad_encoder_emulator #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned PPR      = 12
) (
  input  logic        refclk,
  input  logic        resetN,
  input  logic [15:0] rpm_in,
  input  logic        dir_in,
  input  logic        load,
  output logic        busy,
  output logic        pinA,
  output logic        pinB,
  output logic        pinZ,
  output logic [31:0] step_period,
  output logic [31:0] rev_count
);

  localparam int unsigned POS_W = (4 * PPR > 1) ? $clog2(4 * PPR) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(4 * PPR - 1);
  localparam logic [39:0] DIVIDEND = 40'(64'(CLK_FREQ) * 64'd60);
  localparam logic [21:0] STEPS_PER_REV = 22'(4 * PPR);
  localparam logic [5:0] LAST_ITER = 6'd39;

  typedef enum logic [1:0] {IDLE, DIV, RUN} state_t;

  state_t           state;
  logic [15:0]      rpm_lat;
  logic             dir_lat;
  logic             run_dir;
  logic [21:0]      rem;
  logic [39:0]      quo;
  logic [5:0]       iter;
  logic [31:0]      step_cnt;
  logic [POS_W-1:0] pos;

  logic [21:0]      divisor;
  logic [22:0]      shifted;
  logic             ge;
  logic [21:0]      rem_n;
  logic [39:0]      quo_n;
  logic [31:0]      period_q;

  logic             adv;
  logic             wrap;
  logic [POS_W-1:0] pos_adv;
  logic             nxt_a;
  logic             nxt_b;

  // One restoring-division iteration plus result saturation/clamping.
  always_comb begin
    divisor  = 22'(rpm_lat) * STEPS_PER_REV;
    shifted  = {rem, quo[39]};
    ge       = (shifted >= {1'b0, divisor});
    rem_n    = ge ? 22'(shifted - {1'b0, divisor}) : shifted[21:0];
    quo_n    = {quo[38:0], ge};
    period_q = quo_n[31:0];
    if (|quo_n[39:32]) begin
      period_q = '1;
    end else if (quo_n[31:0] == '0) begin
      period_q = 32'd1;
    end
  end

  // Step timing and next quadrature/position values for the running direction.
  always_comb begin
    adv     = (step_period != '0) && (step_cnt == step_period - 32'd1);
    wrap    = run_dir ? (pos == POS_LAST) : (pos == '0);
    pos_adv = pos;
    nxt_a   = pinA;
    nxt_b   = pinB;
    if (run_dir) begin
      pos_adv = (pos == POS_LAST) ? '0 : pos + 1'b1;
      nxt_a   = ~pinB;
      nxt_b   = pinA;
    end else begin
      pos_adv = (pos == '0) ? POS_LAST : pos - 1'b1;
      nxt_a   = pinB;
      nxt_b   = ~pinA;
    end
  end

  // Control FSM, divider registers and step generator. Stepping keys off a
  // nonzero step_period so the old rate keeps running while a new one divides.
  always_ff @(posedge refclk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      busy        <= 1'b0;
      rpm_lat     <= '0;
      dir_lat     <= 1'b1;
      run_dir     <= 1'b1;
      rem         <= '0;
      quo         <= '0;
      iter        <= '0;
      step_cnt    <= '0;
      step_period <= '0;
      pos         <= '0;
      pinA        <= 1'b0;
      pinB        <= 1'b0;
      rev_count   <= '0;
    end else begin
      if (step_period != '0) begin
        if (adv) begin
          step_cnt <= '0;
          pinA     <= nxt_a;
          pinB     <= nxt_b;
          pos      <= pos_adv;
          if (wrap) begin
            rev_count <= rev_count + 32'd1;
          end
        end else begin
          step_cnt <= step_cnt + 32'd1;
        end
      end
      case (state)
        IDLE, RUN: begin
          if (load) begin
            if (rpm_in == '0) begin
              step_period <= '0;
              step_cnt    <= '0;
              state       <= IDLE;
            end else begin
              rpm_lat <= rpm_in;
              dir_lat <= dir_in;
              rem     <= '0;
              quo     <= DIVIDEND;
              iter    <= '0;
              busy    <= 1'b1;
              state   <= DIV;
            end
          end
        end
        DIV: begin
          rem  <= rem_n;
          quo  <= quo_n;
          iter <= iter + 6'd1;
          if (iter == LAST_ITER) begin
            step_period <= period_q;
            run_dir     <= dir_lat;
            step_cnt    <= '0;
            busy        <= 1'b0;
            state       <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef QENC_INDEX_EN
  // Index: high for the whole step spent at position 0 while generating.
  always_ff @(posedge refclk or negedge resetN) begin
    if (!resetN) begin
      pinZ <= 1'b0;
    end else if (state != DIV && load && rpm_in == '0) begin
      pinZ <= 1'b0;
    end else if (state == DIV && iter == LAST_ITER) begin
      pinZ <= ((adv ? pos_adv : pos) == '0);
    end else if (adv) begin
      pinZ <= (pos_adv == '0);
    end
  end
`else
  assign pinZ = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed bench for quad_encoder_emulator, scaled to CLK_FREQ=100000 so
// 1250 RPM gives a 100-cycle step and a 4800-cycle revolution.
module tb_quad_encoder_emulator;

`ifdef QENC_INDEX_EN
  localparam bit IDX = 1'b1;
`else
  localparam bit IDX = 1'b0;
`endif

  logic        refclk = 1'b0;
  logic        resetN = 1'b0;
  logic [15:0] rpm_in = '0;
  logic        dir_in = 1'b0;
  logic        load   = 1'b0;
  logic        busy;
  logic        pinA;
  logic        pinB;
  logic        pinZ;
  logic [31:0] step_period;
  logic [31:0] rev_count;

  int checks = 0;
  int errors = 0;

  logic prev_a = 1'b0;
  logic prev_b = 1'b0;
  bit   double_toggle = 1'b0;
  bit   z_seen = 1'b0;

  quad_encoder_emulator #(.CLK_FREQ(100000), .PPR(12)) dut (
    .refclk      (refclk),
    .resetN      (resetN),
    .rpm_in      (rpm_in),
    .dir_in      (dir_in),
    .load        (load),
    .busy        (busy),
    .pinA        (pinA),
    .pinB        (pinB),
    .pinZ        (pinZ),
    .step_period (step_period),
    .rev_count   (rev_count)
  );

  always #5 refclk = ~refclk;

  // Watch for both channels moving in one cycle and for any index activity.
  always @(negedge refclk) begin
    if (resetN && (pinA !== prev_a) && (pinB !== prev_b)) double_toggle <= 1'b1;
    if (pinZ === 1'b1) z_seen <= 1'b1;
    prev_a <= pinA;
    prev_b <= pinB;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge refclk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] r, input logic d);
    rpm_in = r;
    dir_in = d;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++; if ({pinA, pinB} !== 2'b00) begin errors++; $display("FAIL reset_pins got %b want 00", {pinA, pinB}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (pinZ !== 1'b0) begin errors++; $display("FAIL reset_pinz got %b want 0", pinZ); end
    checks++; if (step_period !== 32'd0) begin errors++; $display("FAIL reset_period got %0d want 0", step_period); end
    checks++; if (rev_count !== 32'd0) begin errors++; $display("FAIL reset_rev got %0d want 0", rev_count); end
    #4 resetN = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_forward;
    bit ok = 1'b1;
    do_load(16'd1250, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fwd_busy_start got %b want 1", busy); end
    repeat (39) begin tick(); if (busy !== 1'b1) ok = 1'b0; end
    checks++; if (!ok) begin errors++; $display("FAIL fwd_busy_hold got dropped want high 40 cycles"); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fwd_busy_end got %b want 0", busy); end
    checks++; if (step_period !== 32'd100) begin errors++; $display("FAIL fwd_period got %0d want 100", step_period); end
    checks++; if (pinZ !== IDX) begin errors++; $display("FAIL fwd_index_start got %b want %b", pinZ, IDX); end
    repeat (99) tick();
    checks++; if ({pinA, pinB} !== 2'b00) begin errors++; $display("FAIL fwd_pre_step got %b want 00", {pinA, pinB}); end
    tick();
    checks++; if ({pinA, pinB} !== 2'b10) begin errors++; $display("FAIL fwd_step1 got %b want 10", {pinA, pinB}); end
    checks++; if (pinZ !== 1'b0) begin errors++; $display("FAIL fwd_index_off got %b want 0", pinZ); end
    repeat (99) tick();
    checks++; if ({pinA, pinB} !== 2'b10) begin errors++; $display("FAIL fwd_pre_step2 got %b want 10", {pinA, pinB}); end
    tick();
    checks++; if ({pinA, pinB} !== 2'b11) begin errors++; $display("FAIL fwd_step2 got %b want 11", {pinA, pinB}); end
    repeat (4599) tick();
    checks++; if ({pinA, pinB, rev_count} !== {2'b01, 32'd0}) begin errors++; $display("FAIL fwd_pre_rev got pins %b rev %0d want 01 0", {pinA, pinB}, rev_count); end
    tick();
    checks++; if ({pinA, pinB} !== 2'b00) begin errors++; $display("FAIL fwd_rev_pins got %b want 00", {pinA, pinB}); end
    checks++; if (rev_count !== 32'd1) begin errors++; $display("FAIL fwd_rev_count got %0d want 1", rev_count); end
    checks++; if (pinZ !== IDX) begin errors++; $display("FAIL fwd_index_rev got %b want %b", pinZ, IDX); end
  endtask

  task automatic test_reverse;
    repeat (80) tick();
    do_load(16'd2500, 1'b0);
    repeat (18) tick();
    checks++; if ({pinA, pinB} !== 2'b00) begin errors++; $display("FAIL rev_old_pre got %b want 00", {pinA, pinB}); end
    tick();
    checks++; if ({pinA, pinB, busy} !== 3'b101) begin errors++; $display("FAIL rev_old_step got pins/busy %b want 101", {pinA, pinB, busy}); end
    repeat (21) tick();
    checks++; if ({busy, step_period} !== {1'b0, 32'd50}) begin errors++; $display("FAIL rev_period got busy %b period %0d want 0 50", busy, step_period); end
    repeat (49) tick();
    checks++; if ({pinA, pinB} !== 2'b10) begin errors++; $display("FAIL rev_pre got %b want 10", {pinA, pinB}); end
    tick();
    checks++; if ({pinA, pinB} !== 2'b00) begin errors++; $display("FAIL rev_step1 got %b want 00", {pinA, pinB}); end
    repeat (49) tick();
    checks++; if (rev_count !== 32'd1) begin errors++; $display("FAIL rev_pre_wrap got %0d want 1", rev_count); end
    tick();
    checks++; if ({pinA, pinB} !== 2'b01) begin errors++; $display("FAIL rev_step2 got %b want 01", {pinA, pinB}); end
    checks++; if (rev_count !== 32'd2) begin errors++; $display("FAIL rev_wrap_count got %0d want 2", rev_count); end
  endtask

  task automatic test_stop_restart;
    bit ok = 1'b1;
    repeat (10) tick();
    do_load(16'd0, 1'b1);
    checks++; if ({busy, step_period} !== {1'b0, 32'd0}) begin errors++; $display("FAIL stop_state got busy %b period %0d want 0 0", busy, step_period); end
    repeat (200) begin tick(); if ({pinA, pinB, busy} !== 3'b010) ok = 1'b0; end
    checks++; if (!ok) begin errors++; $display("FAIL stop_frozen got activity want pins 01 busy 0"); end
    do_load(16'd1250, 1'b1);
    repeat (40) tick();
    checks++; if ({busy, step_period} !== {1'b0, 32'd100}) begin errors++; $display("FAIL restart_period got busy %b period %0d want 0 100", busy, step_period); end
    repeat (99) tick();
    checks++; if ({pinA, pinB} !== 2'b01) begin errors++; $display("FAIL restart_pre got %b want 01", {pinA, pinB}); end
    tick();
    checks++; if ({pinA, pinB} !== 2'b00) begin errors++; $display("FAIL restart_step got %b want 00", {pinA, pinB}); end
    checks++; if (rev_count !== 32'd3) begin errors++; $display("FAIL restart_rev got %0d want 3", rev_count); end
  endtask

  task automatic test_load_while_busy;
    bit ok = 1'b1;
    do_load(16'd2500, 1'b1);
    do_load(16'd60, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lwb_busy got %b want 1", busy); end
    repeat (38) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lwb_busy_late got %b want 1", busy); end
    tick();
    checks++; if ({busy, step_period} !== {1'b0, 32'd50}) begin errors++; $display("FAIL lwb_period got busy %b period %0d want 0 50", busy, step_period); end
    repeat (45) begin tick(); if (busy !== 1'b0) ok = 1'b0; end
    checks++; if (!ok || step_period !== 32'd50) begin errors++; $display("FAIL lwb_no_queue got period %0d busy seen %b want 50 none", step_period, !ok); end
  endtask

  task automatic test_period_one;
    logic [1:0] exp_seq [4];
    bit ok = 1'b1;
    exp_seq[0] = 2'b11; exp_seq[1] = 2'b01; exp_seq[2] = 2'b00; exp_seq[3] = 2'b10;
    do_load(16'd65535, 1'b1);
    repeat (3) tick();
    checks++; if ({pinA, pinB} !== 2'b00) begin errors++; $display("FAIL p1_pre got %b want 00", {pinA, pinB}); end
    tick();
    checks++; if ({pinA, pinB} !== 2'b10) begin errors++; $display("FAIL p1_old_step got %b want 10", {pinA, pinB}); end
    repeat (36) tick();
    checks++; if ({busy, step_period, pinA, pinB} !== {1'b0, 32'd1, 2'b10}) begin errors++; $display("FAIL p1_period got busy %b period %0d pins %b want 0 1 10", busy, step_period, {pinA, pinB}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if ({pinA, pinB} !== exp_seq[i]) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL p1_every_cycle got %b want sequence 11 01 00 10", {pinA, pinB}); end
  endtask

  task automatic test_reset_mid;
    bit ok = 1'b1;
    #2 resetN = 1'b0;
    #1;
    checks++; if ({pinA, pinB, pinZ, busy} !== 4'b0000) begin errors++; $display("FAIL rst_run_bits got %b want 0000", {pinA, pinB, pinZ, busy}); end
    checks++; if ({step_period, rev_count} !== 64'd0) begin errors++; $display("FAIL rst_run_counts got period %0d rev %0d want 0 0", step_period, rev_count); end
    #2 resetN = 1'b1;
    repeat (20) begin tick(); if ({pinA, pinB} !== 2'b00) ok = 1'b0; end
    checks++; if (!ok) begin errors++; $display("FAIL rst_run_quiet got toggles want none"); end
    do_load(16'd1250, 1'b1);
    repeat (10) tick();
    #2 resetN = 1'b0;
    #1;
    checks++; if ({busy, step_period} !== {1'b0, 32'd0}) begin errors++; $display("FAIL rst_div got busy %b period %0d want 0 0", busy, step_period); end
    #2 resetN = 1'b1;
    repeat (50) tick();
    checks++; if ({busy, step_period, pinA, pinB} !== {1'b0, 32'd0, 2'b00}) begin errors++; $display("FAIL rst_div_discard got busy %b period %0d pins %b want 0 0 00", busy, step_period, {pinA, pinB}); end
  endtask

  task automatic test_waveform_rules;
    checks++; if (double_toggle !== 1'b0) begin errors++; $display("FAIL double_toggle got 1 want 0"); end
    checks++; if (z_seen !== IDX) begin errors++; $display("FAIL index_activity got %b want %b", z_seen, IDX); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_stop_restart();
    test_load_while_busy();
    test_period_one();
    test_reset_mid();
    test_waveform_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
